node_event_gen: RTL and testbench

//  Producer side of the node-status interface consumed by the LED indicator block.

---
 rtl/node_event_gen.sv | 173 +++++++++++++++++
 tb/tb_node_event_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/node_event_gen.sv
// node_event_gen: producer side of the node-status interface.
// Synchronises and debounces the line and fault sensors, detects path nodes
// (all three line sensors on line) and reports them to the LED/status logic
// as a one-cycle pulse, a running node count, a sticky fault flag and a
// run-complete level.
module node_event_gen #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int FINAL_NODE   = 13,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             line_l,
  input  logic             line_c,
  input  logic             line_r,
  input  logic             fault_in,
  input  logic             fault_ack,
  output logic             node_changed,
  output logic [CNT_W-1:0] node_counter,
  output logic             fault_detect,
  output logic             run_done
);

  localparam int               DB_W      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0]  DB_EXIT   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] FINAL_VAL = CNT_W'(FINAL_NODE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_CONFIRM,
    S_AT_NODE,
    S_DONE
  } state_t;

  // Synchroniser stages: {line_l, line_c, line_r, fault_in}
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  logic node_pat;
  logic fault_s;

  logic [DB_W-1:0]  fcnt_q;
  logic             fault_q;

  state_t           state_q;
  logic [DB_W-1:0]  dcnt_q;
  logic             pulse_q;
  logic [CNT_W-1:0] count_q;
  logic             done_q;
  logic [CNT_W-1:0] count_inc;

  // Two-flop synchronisers for all asynchronous sensor inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking here so sync2_q takes the old sync1_q, giving two real stages.
      sync1_q <= {line_l, line_c, line_r, fault_in};
      sync2_q <= sync1_q;
    end
  end

  assign node_pat = &sync2_q[3:1];
  assign fault_s  = sync2_q[0];

  // Saturating increment of the node count; a full counter stays full.
  always_comb begin
    // NOTE: default first so every path assigns count_inc and no latch is inferred.
    count_inc = count_q;
    if (count_q != CNT_SAT) count_inc = count_q + 1'b1;
  end

  // Fault debounce and sticky flag; a confirmation outranks a same-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (!fault_s)              fcnt_q <= '0;
      else if (fcnt_q != DB_MAX) fcnt_q <= fcnt_q + 1'b1;

      if (fcnt_q == DB_MAX)          fault_q <= 1'b1;
      else if (fault_ack && !fault_s) fault_q <= 1'b0;
    end
  end

  // Node tracking FSM with registered pulse, count and run-done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: default low here; a later assignment in this block wins for that cycle.
      pulse_q <= 1'b0;
      if (state_q != S_IDLE && !enable) begin
        // Dropping enable abandons the run; count and run_done stay visible.
        state_q <= S_IDLE;
        dcnt_q  <= '0;
      end else if (fault_q) begin
        // A confirmed fault freezes tracking and discards partial debounce.
        dcnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            dcnt_q <= '0;
            if (enable) begin
              state_q <= S_TRACK;
              count_q <= '0;
              done_q  <= 1'b0;
            end
          end
          S_TRACK: begin
            if (node_pat) begin
              state_q <= S_CONFIRM;
              dcnt_q  <= DB_ONE;
            end
          end
          S_CONFIRM: begin
            if (dcnt_q == DB_MAX) begin
              pulse_q <= 1'b1;
              dcnt_q  <= '0;
              count_q <= count_inc;
              if (count_inc == FINAL_VAL) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_AT_NODE;
              end
            end else if (!node_pat) begin
              state_q <= S_TRACK;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          S_AT_NODE: begin
            // Leave the node only after a full run of clear samples.
            if (node_pat) begin
              dcnt_q <= '0;
            end else if (dcnt_q == DB_EXIT) begin
              state_q <= S_TRACK;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          S_DONE: begin
            dcnt_q <= '0;
          end
          default: begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign node_changed = pulse_q;
  assign node_counter = count_q;
  assign fault_detect = fault_q;
  assign run_done     = done_q;

endmodule

// File: tb/tb_node_event_gen.sv
// tb_node_event_gen: randomized scoreboard bench for node_event_gen.
// Stimulus tasks predict each node pulse from the sensor rules and queue the
// expected node count; an independent monitor pops on every pulse.
module tb_node_event_gen;

  localparam int DEB   = 4;
  localparam int FINAL = 13;
  localparam int CW    = 6;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          line_l, line_c, line_r;
  logic          fault_in;
  logic          fault_ack;
  logic          node_changed;
  logic [CW-1:0] node_counter;
  logic          fault_detect;
  logic          run_done;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  // Reference model state: run level, node count, done, fault.
  int m_count = 0;
  bit m_done  = 1'b0;
  bit m_fault = 1'b0;
  bit m_en    = 1'b0;

  node_event_gen #(
    .DEBOUNCE_CYC(DEB),
    .FINAL_NODE  (FINAL),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .line_l      (line_l),
    .line_c      (line_c),
    .line_r      (line_r),
    .fault_in    (fault_in),
    .fault_ack   (fault_ack),
    .node_changed(node_changed),
    .node_counter(node_counter),
    .fault_detect(fault_detect),
    .run_done    (run_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lines(input logic [2:0] p);
    {line_l, line_c, line_r} = p;
  endtask

  // A pattern held for h cycles counts as a node when it is 111, lasts at
  // least DEB cycles, and the run is enabled, not finished and fault-free.
  task automatic drive_node(input int h, input int g, input logic [2:0] pat);
    bit hit;
    hit = (pat == 3'b111) && (h >= DEB) && m_en && !m_fault && !m_done;
    if (hit) begin
      m_count = (m_count < SAT) ? m_count + 1 : SAT;
      exp_q.push_back(m_count);
      if (m_count == FINAL) m_done = 1'b1;
    end
    set_lines(pat);
    cycles(h);
    set_lines(3'b000);
    cycles(g);
  endtask

  task automatic random_node();
    logic [2:0] pat;
    pat = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 6));
    drive_node(int'($urandom_range(1, 8)), int'($urandom_range(6, 10)), pat);
  endtask

  task automatic ack_pulse();
    fault_ack = 1'b1;
    cycles(1);
    fault_ack = 1'b0;
  endtask

  // Monitor: every pulse must match the next queued node count.
  always @(negedge clk) begin
    if (!rst && node_changed) begin
      if (exp_q.size() == 0) check("unexpected_pulse", int'(node_changed), 0);
      else                   check("pulse_counter", int'(node_counter), exp_q.pop_front());
    end
  end

  initial begin
    int pulses;
    int at_edge;
    int guard;

    rst = 1'b1; enable = 1'b0; fault_in = 1'b0; fault_ack = 1'b0;
    set_lines(3'b000);
    cycles(2);
    check("rst_node_changed", int'(node_changed), 0);
    check("rst_node_counter", int'(node_counter), 0);
    check("rst_fault_detect", int'(fault_detect), 0);
    check("rst_run_done",     int'(run_done), 0);
    rst = 1'b0;
    cycles(1);

    // First node: pulse timing from the raw rise.
    enable = 1'b1; m_en = 1'b1; m_count = 0; m_done = 1'b0;
    cycles(2);
    m_count = 1;
    exp_q.push_back(1);
    set_lines(3'b111);
    pulses = 0; at_edge = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (node_changed) begin pulses++; at_edge = k; end
    end
    @(negedge clk);
    set_lines(3'b000);
    cycles(8);
    check("t1_pulse_count", pulses, 1);
    check("t1_pulse_edge", at_edge, DEB + 3);
    check("t1_counter", int'(node_counter), 1);

    // Glitch shorter than the debounce window.
    drive_node(DEB - 1, 8, 3'b111);
    check("t2_counter", int'(node_counter), m_count);

    // Random node/gap traffic until the final node.
    guard = 0;
    while (!m_done && guard < 400) begin
      random_node();
      guard++;
    end
    check("t3_reached_final", int'(m_done), 1);
    check("t3_counter", int'(node_counter), FINAL);
    check("t3_run_done", int'(run_done), 1);
    drive_node(DEB + 2, 8, 3'b111);
    check("t3_counter_held", int'(node_counter), FINAL);
    enable = 1'b0; m_en = 1'b0;
    cycles(2);
    check("t3_idle_counter", int'(node_counter), FINAL);
    check("t3_idle_run_done", int'(run_done), 1);
    enable = 1'b1; m_en = 1'b1; m_count = 0; m_done = 1'b0;
    cycles(2);
    check("t3_restart_counter", int'(node_counter), 0);
    check("t3_restart_run_done", int'(run_done), 0);

    // Fault confirmation, suppression, and ack rules.
    fault_in = 1'b1;
    cycles(DEB + 2);
    fault_in = 1'b0;
    check("t4_not_early", int'(fault_detect), 0);
    cycles(2);
    check("t4_fault_set", int'(fault_detect), 1);
    m_fault = 1'b1;
    drive_node(DEB + 2, 8, 3'b111);
    drive_node(DEB + 3, 8, 3'b111);
    check("t4_counter_frozen", int'(node_counter), m_count);
    fault_in = 1'b1;
    cycles(2);
    fault_ack = 1'b1;
    fault_in = 1'b0;
    cycles(1);
    fault_ack = 1'b0;
    check("t4_ack_while_fault", int'(fault_detect), 1);
    cycles(4);
    ack_pulse();
    check("t4_ack_clears", int'(fault_detect), 0);
    m_fault = 1'b0;
    drive_node(DEB + 1, 8, 3'b111);
    check("t4_resume_counter", int'(node_counter), m_count);

    // Confirmation and ack land in the same cycle.
    fault_in = 1'b1;
    cycles(DEB + 2);
    fault_ack = 1'b1;
    cycles(1);
    fault_ack = 1'b0;
    check("t5_set_wins", int'(fault_detect), 1);
    m_fault = 1'b1;
    fault_in = 1'b0;
    cycles(4);
    ack_pulse();
    check("t5_cleared", int'(fault_detect), 0);
    m_fault = 1'b0;

    // Build up to five nodes, then reset in the middle of a confirmation.
    guard = 0;
    while (m_count < 5 && guard < 200) begin
      drive_node(int'($urandom_range(DEB, DEB + 4)), int'($urandom_range(6, 10)), 3'b111);
      guard++;
    end
    check("t6_counter_before", int'(node_counter), 5);
    set_lines(3'b111);
    cycles(DEB - 2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_rst_counter",  int'(node_counter), 0);
    check("t6_rst_pulse",    int'(node_changed), 0);
    check("t6_rst_run_done", int'(run_done), 0);
    check("t6_rst_fault",    int'(fault_detect), 0);
    m_count = 0; m_done = 1'b0; m_fault = 1'b0;
    @(negedge clk);
    set_lines(3'b000);
    cycles(3);
    rst = 1'b0;
    cycles(2);
    drive_node(DEB + 2, 8, 3'b111);
    check("t6_counter_after", int'(node_counter), 1);

    cycles(4);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
